// File: rtl/title_char_loader.sv
// Loads a 12-character song title from a synchronous title ROM and presents
// it as registered 9-bit glyph codes char1..char12 with busy/title_valid.
module title_char_loader #(
    parameter int         SONG_BITS  = 2,
    parameter logic [8:0] BLANK_CODE = 9'h100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SONG_BITS-1:0]   song_id,
    output logic [SONG_BITS+3:0]   rom_addr,
    input  logic [7:0]             rom_data,
    output logic [8:0]             char1,
    output logic [8:0]             char2,
    output logic [8:0]             char3,
    output logic [8:0]             char4,
    output logic [8:0]             char5,
    output logic [8:0]             char6,
    output logic [8:0]             char7,
    output logic [8:0]             char8,
    output logic [8:0]             char9,
    output logic [8:0]             char10,
    output logic [8:0]             char11,
    output logic [8:0]             char12,
    output logic                   busy,
    output logic                   title_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd11;

    state_t                 state_reg, state_next;
    logic [3:0]             idx_reg, idx_next;
    logic [SONG_BITS-1:0]   song_reg, song_next;
    logic                   term_reg, term_next;
    logic                   busy_reg, busy_next;
    logic                   valid_reg, valid_next;

    logic                   cap_en;
    logic [3:0]             cap_sel;
    logic [8:0]             glyph;
    logic                   byte_is_nul;
    logic [8:0]             cap_code;

    logic [8:0]             char_reg [12];
    logic [11:0]            char_we;

    // Letters of either case share the same low five bits (1..26), which is
    // exactly the glyph row index before the <<3 scaling.
    always_comb begin
        glyph = BLANK_CODE;
        if ((rom_data >= 8'h61 && rom_data <= 8'h7A) ||
            (rom_data >= 8'h41 && rom_data <= 8'h5A)) begin
            glyph = {1'b0, rom_data[4:0], 3'b000};
        end
    end

    assign byte_is_nul = (rom_data == 8'h00);
    assign cap_code    = (term_reg || byte_is_nul) ? BLANK_CODE : glyph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            song_reg  <= '0;
            term_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            song_reg  <= song_next;
            term_reg  <= term_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        song_next  = song_reg;
        term_next  = term_reg;
        busy_next  = busy_reg;
        valid_next = valid_reg;
        cap_en     = 1'b0;
        cap_sel    = idx_reg - 4'd1;

        case (state_reg)
            IDLE, DONE: begin
                if (load) begin
                    state_next = FETCH;
                    idx_next   = 4'd0;
                    song_next  = song_id;
                    term_next  = 1'b0;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                end
            end

            FETCH: begin
                // rom_data lags the presented address by one cycle, so the
                // byte arriving now belongs to idx_reg-1.
                if (idx_reg != 4'd0) begin
                    cap_en    = 1'b1;
                    term_next = term_reg | byte_is_nul;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = LAST;
                end else begin
                    idx_next = idx_reg + 4'd1;
                end
            end

            LAST: begin
                cap_en     = 1'b1;
                cap_sel    = LAST_IDX;
                term_next  = term_reg | byte_is_nul;
                state_next = DONE;
                busy_next  = 1'b0;
                valid_next = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_char_we
            assign char_we[gi] = cap_en && (cap_sel == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) begin
                char_reg[i] <= BLANK_CODE;
            end
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (char_we[i]) begin
                    char_reg[i] <= cap_code;
                end
            end
        end
    end

    // Address is built from registered state only; it holds after the load.
    assign rom_addr    = {song_reg, idx_reg};
    assign busy        = busy_reg;
    assign title_valid = valid_reg;

    assign char1  = char_reg[0];
    assign char2  = char_reg[1];
    assign char3  = char_reg[2];
    assign char4  = char_reg[3];
    assign char5  = char_reg[4];
    assign char6  = char_reg[5];
    assign char7  = char_reg[6];
    assign char8  = char_reg[7];
    assign char9  = char_reg[8];
    assign char10 = char_reg[9];
    assign char11 = char_reg[10];
    assign char12 = char_reg[11];

endmodule

// File: tb/tb_title_char_loader.sv
// Directed bench for title_char_loader: synchronous ROM model, per-cycle
// address/flag/char checks, and a scoreboard of expected titles.
module tb_title_char_loader;

    typedef logic [11:0][8:0] title_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [1:0] song_id;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [8:0] char1, char2, char3, char4, char5, char6;
    logic [8:0] char7, char8, char9, char10, char11, char12;
    logic       busy;
    logic       title_valid;

    logic [7:0] rom [64];
    title_t     titles [4];
    title_t     shown;
    title_t     exp_q [$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    title_char_loader #(
        .SONG_BITS  (2),
        .BLANK_CODE (9'h100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .song_id     (song_id),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .char1       (char1),
        .char2       (char2),
        .char3       (char3),
        .char4       (char4),
        .char5       (char5),
        .char6       (char6),
        .char7       (char7),
        .char8       (char8),
        .char9       (char9),
        .char10      (char10),
        .char11      (char11),
        .char12      (char12),
        .busy        (busy),
        .title_valid (title_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] dut_char(input int n);
        case (n)
            1:  return char1;
            2:  return char2;
            3:  return char3;
            4:  return char4;
            5:  return char5;
            6:  return char6;
            7:  return char7;
            8:  return char8;
            9:  return char9;
            10: return char10;
            11: return char11;
            default: return char12;
        endcase
    endfunction

    task automatic put_str(input int song, input string s);
        for (int i = 0; i < s.len(); i++) rom[song * 16 + i] = s[i];
    endtask

    task automatic check_reset_values(input string tag);
        for (int n = 1; n <= 12; n++)
            check($sformatf("%s char%0d", tag, n), 32'(dut_char(n)), 32'h100);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " valid"}, 32'(title_valid), 32'd0);
        check({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // Drives one load of song s and follows it cycle by cycle through E13.
    // poke_cycle != 0 re-asserts load (with another song_id) during that cycle.
    task automatic run_load(input logic [1:0] s, input int poke_cycle);
        title_t exp;
        title_t got;
        exp = titles[s];
        exp_q.push_back(exp);
        load    = 1'b1;
        song_id = s;
        tick();
        load    = 1'b0;
        song_id = ~s;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 12)
                check($sformatf("s%0d c%0d rom_addr", s, c), 32'(rom_addr), 32'({s, 4'(c - 1)}));
            else
                check($sformatf("s%0d c%0d rom_addr", s, c), 32'(rom_addr), 32'({s, 4'd11}));
            check($sformatf("s%0d c%0d busy", s, c), 32'(busy), 32'd1);
            check($sformatf("s%0d c%0d valid", s, c), 32'(title_valid), 32'd0);
            for (int n = 1; n <= 12; n++) begin
                logic [8:0] want;
                want = (n + 1 <= c - 1) ? exp[n - 1] : shown[n - 1];
                check($sformatf("s%0d c%0d char%0d", s, c, n), 32'(dut_char(n)), 32'(want));
            end
            if (c == poke_cycle) begin
                load    = 1'b1;
                song_id = 2'd1;
            end
            tick();
            load = 1'b0;
        end
        check($sformatf("s%0d end busy", s), 32'(busy), 32'd0);
        check($sformatf("s%0d end valid", s), 32'(title_valid), 32'd1);
        check($sformatf("s%0d end rom_addr", s), 32'(rom_addr), 32'({s, 4'd11}));
        check($sformatf("s%0d scoreboard depth", s), 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            for (int n = 1; n <= 12; n++)
                check($sformatf("s%0d final char%0d", s, n), 32'(dut_char(n)), 32'(got[n - 1]));
            shown = got;
        end
        $display("load song=%0d poke=%0d checked through E13", s, poke_cycle);
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        song_id = 2'd0;

        for (int i = 0; i < 64; i++) rom[i] = 8'h58 + 8'(i % 3);
        put_str(0, "pink panther");
        put_str(1, "abc&        ");
        put_str(2, "Jaws");
        rom[2 * 16 + 4] = 8'h00;
        put_str(3, "Ab1Zz@[`{aY~");

        titles[0] = {9'h090, 9'h028, 9'h040, 9'h0A0, 9'h070, 9'h008,
                     9'h080, 9'h100, 9'h058, 9'h070, 9'h048, 9'h080};
        titles[1] = {9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100,
                     9'h100, 9'h100, 9'h100, 9'h018, 9'h010, 9'h008};
        titles[2] = {9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100,
                     9'h100, 9'h100, 9'h098, 9'h0B8, 9'h008, 9'h050};
        titles[3] = {9'h100, 9'h0C8, 9'h008, 9'h100, 9'h100, 9'h100,
                     9'h100, 9'h0D0, 9'h0D0, 9'h100, 9'h010, 9'h008};
        for (int n = 0; n < 12; n++) shown[n] = 9'h100;

        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check_reset_values("idle");
        $display("reset and idle checked");

        run_load(2'd0, 0);
        run_load(2'd2, 5);
        run_load(2'd1, 0);

        // Reset in cycle 7 of a load must clear everything without a clock edge.
        load    = 1'b1;
        song_id = 2'd3;
        tick();
        load = 1'b0;
        repeat (6) tick();
        check("mid-load busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("async reset");
        exp_q.delete();
        for (int n = 0; n < 12; n++) shown[n] = 9'h100;
        tick();
        reset = 1'b0;
        tick();
        $display("async reset mid-load checked");
        run_load(2'd3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
